led_out: RTL

LED_OUT -- requirements
Module: led_out

---
 rtl/led_out_pkg.sv | 12 +
 rtl/led_out_ch.sv | 86 ++++++++
 rtl/led_out.sv | 51 +++++
 3 files changed

// File: rtl/led_out_pkg.sv
// Shared definitions for the LED hold/blink output block (optional blink: LED_OUT_BLINK_EN).
// Holds the per-channel state encoding and the channel count.
package led_out_pkg;

   localparam int NUM_CH = 4;

   typedef enum logic {
      IDLE = 1'b0,
      ON   = 1'b1
   } ch_state_t;

endpackage

// File: rtl/led_out_ch.sv
// One LED channel: IDLE/ON FSM with a tick-based hold counter (blink phase when LED_OUT_BLINK_EN).
// Handshake: i_pin is a level sampled every cycle; each high cycle is a (re)trigger, no ready.
module led_out_ch
   import led_out_pkg::*;
#(
   parameter int HOLD_TICKS = 8
) (
   input  logic      CLK,
   input  logic      RST,
   input  logic      i_pin,
   input  logic      i_tick,
   output logic      o_nlout,
   output logic      o_busy,
   output ch_state_t o_state
);

   localparam int              HW        = $clog2(HOLD_TICKS + 1);
   localparam logic [HW-1:0]   HOLD_LOAD = HW'(HOLD_TICKS);
   localparam logic [HW-1:0]   HOLD_LAST = HW'(1);

   ch_state_t       r_state;
   logic [HW-1:0]   r_hold;
   logic            r_busy;
   logic            r_nlout;
`ifdef LED_OUT_BLINK_EN
   logic            r_lit;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= IDLE;
         r_hold  <= '0;
         r_busy  <= 1'b0;
         r_nlout <= 1'b1;
`ifdef LED_OUT_BLINK_EN
         r_lit   <= 1'b1;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (i_pin) begin
                  r_state <= ON;
                  r_hold  <= HOLD_LOAD;
                  r_busy  <= 1'b1;
                  r_nlout <= 1'b0;
`ifdef LED_OUT_BLINK_EN
                  r_lit   <= 1'b1;
`endif
               end
            end
            ON: begin
               // A request in the same cycle as a tick reloads and suppresses the decrement.
               if (i_pin) begin
                  r_hold  <= HOLD_LOAD;
                  r_nlout <= 1'b0;
`ifdef LED_OUT_BLINK_EN
                  r_lit   <= 1'b1;
`endif
               end else if (i_tick) begin
                  if (r_hold == HOLD_LAST) begin
                     r_state <= IDLE;
                     r_hold  <= '0;
                     r_busy  <= 1'b0;
                     r_nlout <= 1'b1;
`ifdef LED_OUT_BLINK_EN
                     r_lit   <= 1'b1;
`endif
                  end else begin
                     r_hold  <= r_hold - HW'(1);
`ifdef LED_OUT_BLINK_EN
                     // New phase is ~r_lit, so the active-low drive equals the old phase.
                     r_lit   <= ~r_lit;
                     r_nlout <= r_lit;
`endif
                  end
               end
            end
         endcase
      end
   end

   assign o_nlout = r_nlout;
   assign o_busy  = r_busy;
   assign o_state = r_state;

endmodule

// File: rtl/led_out.sv
// Four-channel LED hold driver with a shared free-running tick divider (blink: LED_OUT_BLINK_EN).
// o_dbg_on mirrors each channel FSM (1 = ON) for observation.
module led_out
   import led_out_pkg::*;
#(
   parameter int TICK_DIV   = 1250000,
   parameter int HOLD_TICKS = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [NUM_CH-1:0] PIN,
   output logic [NUM_CH-1:0] nLOUT,
   output logic [NUM_CH-1:0] BUSY,
   output logic [NUM_CH-1:0] o_dbg_on
);

   localparam int            CW        = $clog2(TICK_DIV);
   localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] r_tick_cnt;
   logic          w_tick;
   ch_state_t     w_state [NUM_CH];

   assign w_tick = (r_tick_cnt == TICK_LAST);

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_tick_cnt <= '0;
      end else if (w_tick) begin
         r_tick_cnt <= '0;
      end else begin
         r_tick_cnt <= r_tick_cnt + CW'(1);
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      led_out_ch #(
         .HOLD_TICKS (HOLD_TICKS)
      ) u_ch (
         .CLK     (CLK),
         .RST     (RST),
         .i_pin   (PIN[g]),
         .i_tick  (w_tick),
         .o_nlout (nLOUT[g]),
         .o_busy  (BUSY[g]),
         .o_state (w_state[g])
      );
      assign o_dbg_on[g] = (w_state[g] == ON);
   end

endmodule
